// File: rtl/int_square_if.sv
//------------------------------------------------------------------------------
// int_square_if : operand/result bundle for the sequential integer squarer
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface int_square_if #(
    parameter int WIDTH = 24
) ();
    logic                   start_i;
    logic [WIDTH/2-1:0]     q_i;
    logic [WIDTH-1:0]       r_i;
    logic [WIDTH-1:0]       n_o;
    logic                   err_o;
    logic                   valid_o;
    logic                   busy_o;

    modport master (
        output start_i, q_i, r_i,
        input  n_o, err_o, valid_o, busy_o
    );

    modport slave (
        input  start_i, q_i, r_i,
        output n_o, err_o, valid_o, busy_o
    );
endinterface

`default_nettype wire

// File: rtl/int_square.sv
//------------------------------------------------------------------------------
// int_square : rebuilds n = q*q + r with one shift-add per root bit, MSB first
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module int_square #(
    parameter int WIDTH = 24
) (
    input  wire logic       clk_i,
    input  wire logic       reset_i,
    int_square_if.slave     bus
);
    localparam int c_qw    = WIDTH / 2;
    localparam int c_cnt_w = $clog2(c_qw) + 1;
    localparam int c_idx_w = (c_qw > 1) ? $clog2(c_qw) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [c_qw-1:0]        r_qr;
    logic [WIDTH-1:0]       r_rr;
    logic [WIDTH:0]         r_acc;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [WIDTH-1:0]       r_n;
    logic                   r_err;
    logic                   r_valid;

    logic                   w_qbit;
    logic [WIDTH:0]         w_sum;
    logic                   w_unused;

    // State register
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start_i) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == '0) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_qbit   = r_qr[r_cnt[c_idx_w-1:0]];
    assign w_sum    = r_acc + {1'b0, r_rr};
    // Carry out of the final sum is deliberately dropped (modulo 2^WIDTH result).
    assign w_unused = w_sum[WIDTH];

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_qr    <= '0;
            r_rr    <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_n     <= '0;
            r_err   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        r_qr  <= bus.q_i;
                        r_rr  <= bus.r_i;
                        r_acc <= '0;
                        r_cnt <= c_cnt_w'(c_qw - 1);
                    end
                end
                S_RUN: begin
                    r_acc <= (r_acc << 1)
                           + (w_qbit ? {{(c_qw + 1){1'b0}}, r_qr} : {(WIDTH + 1){1'b0}});
                    r_cnt <= r_cnt - c_cnt_w'(1);
                end
                S_DONE: begin
                    r_n   <= w_sum[WIDTH-1:0];
                    r_err <= (r_rr > {{(c_qw - 1){1'b0}}, r_qr, 1'b0});
                end
                default: ;
            endcase
        end
    end

    assign bus.n_o     = r_n;
    assign bus.err_o   = r_err;
    assign bus.valid_o = r_valid;
    assign bus.busy_o  = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_int_square.sv
//------------------------------------------------------------------------------
// tb_int_square : scoreboard bench for int_square (WIDTH = 24)
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_int_square;
    localparam int WIDTH = 24;

    typedef struct {
        logic [WIDTH-1:0] n;
        logic             err;
        int               t;
    } exp_t;

    logic clk;
    logic reset_n;
    int   cyc;
    int   checks;
    int   errors;
    logic prev_valid;
    exp_t sb[$];

    int_square_if #(.WIDTH(WIDTH)) bus ();

    int_square #(.WIDTH(WIDTH)) dut (
        .clk_i   (clk),
        .reset_i (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: every valid pulse is matched against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (bus.valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid actual=1 required=0 n=%0d", bus.n_o);
            end else begin
                e = sb.pop_front();
                chk("n_o",          32'(bus.n_o),   32'(e.n));
                chk("err_o",        32'(bus.err_o), 32'(e.err));
                chk("latency",      32'(cyc),       32'(e.t));
                chk("valid_single", 32'(prev_valid), 32'd0);
            end
        end
        prev_valid <= bus.valid_o;
    end

    task automatic wait_valid(input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (bus.valid_o === 1'b1) return;
        end
        checks++;
        errors++;
        $display("FAIL valid_timeout actual=0 required=1");
    endtask

    // Issue one operation at the current negedge and wait for its result
    task automatic op(input logic [11:0] q, input logic [23:0] r,
                      input logic [23:0] n, input logic e);
        bus.start_i = 1'b1;
        bus.q_i     = q;
        bus.r_i     = r;
        sb.push_back('{n, e, cyc + 14});
        @(negedge clk);
        bus.start_i = 1'b0;
        chk("busy_after_start", 32'(bus.busy_o), 32'd1);
        wait_valid(20);
    endtask

    initial begin
        int q;
        int r;
        prev_valid  = 1'b0;
        checks      = 0;
        errors      = 0;
        reset_n     = 1'b0;
        bus.start_i = 1'b0;
        bus.q_i     = '0;
        bus.r_i     = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_n_o",     32'(bus.n_o),     32'd0);
        chk("reset_err_o",   32'(bus.err_o),   32'd0);
        chk("reset_valid_o", 32'(bus.valid_o), 32'd0);
        chk("reset_busy_o",  32'(bus.busy_o),  32'd0);

        // Directed vectors
        op(12'd0,    24'd0,    24'd0,        1'b0);
        op(12'd1234, 24'd100,  24'd1522856,  1'b0);
        op(12'd4095, 24'd8190, 24'd16777215, 1'b0);
        op(12'd4095, 24'd8191, 24'd0,        1'b1);
        op(12'd5,    24'd11,   24'd36,       1'b1);
        op(12'd1,    24'd2,    24'd3,        1'b0);
        op(12'd2048, 24'd0,    24'd4194304,  1'b0);

        // Start during busy is dropped; start in the valid cycle is taken
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.q_i     = 12'd3;
        bus.r_i     = 24'd2;
        sb.push_back('{24'd11, 1'b0, cyc + 14});
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_cycle4", 32'(bus.busy_o), 32'd1);
        bus.start_i = 1'b1;
        bus.q_i     = 12'd7;
        bus.r_i     = 24'd0;
        @(negedge clk);
        bus.start_i = 1'b0;
        wait_valid(20);
        op(12'd7, 24'd0, 24'd49, 1'b0);

        // Held start: one acceptance every 14 cycles
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.q_i     = 12'd9;
        bus.r_i     = 24'd3;
        sb.push_back('{24'd84, 1'b0, cyc + 14});
        sb.push_back('{24'd84, 1'b0, cyc + 28});
        sb.push_back('{24'd84, 1'b0, cyc + 42});
        repeat (30) @(negedge clk);
        bus.start_i = 1'b0;
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);

        // Round-trip: any valid (root, remainder) pair reconstructs its radicand
        for (int k = 0; k < 100; k++) begin
            q = int'($urandom_range(4095, 0));
            r = int'($urandom_range(2 * q, 0));
            op(12'(q), 24'(r), 24'(q * q + r), 1'b0);
        end

        // Reset in the middle of a run aborts with no result
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.q_i     = 12'd100;
        bus.r_i     = 24'd0;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_busy_o",  32'(bus.busy_o),  32'd0);
        chk("abort_n_o",     32'(bus.n_o),     32'd0);
        chk("abort_err_o",   32'(bus.err_o),   32'd0);
        chk("abort_valid_o", 32'(bus.valid_o), 32'd0);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/int_square.md
# int_square

Sequential integer squarer: the inverse of the integer square-root unit. Given a root `q_i` and remainder `r_i`, it reconstructs `n_o = q_i*q_i + r_i` using one shift-add step per root bit. It also flags remainders that a square-root unit could not have produced. It sits beside the square-root unit in the FPU datapath for result checking and self-test round-trips, and shares that unit's start/valid handshake and `WIDTH` parameter.

## Interface
- `WIDTH`, default 24: radicand width. Must be even and ≥4. Root width is `WIDTH/2`.

Ports (clock and reset first):
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `reset_i`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk_i`.
- `start_i`  in  1  request; accepted only in IDLE.
- `q_i`  in  WIDTH/2  root operand.
- `r_i`  in  WIDTH  remainder operand.
- `n_o`  out  WIDTH  result `(q^2 + r) mod 2^WIDTH`; reset 0.
- `err_o`  out  1  set when `r > 2*q` (invalid remainder); reset 0.
- `valid_o`  out  1  one-cycle pulse when `n_o` and `err_o` update; reset 0.
- `busy_o`  out  1  high when state ≠ IDLE; reset 0.

## Operation
- **States:** IDLE, RUN, DONE; 2-bit encoding.
  - IDLE → RUN on `start_i`.
  - RUN → DONE when the bit counter reaches 0.
  - DONE → IDLE unconditionally.
- **IDLE with `start_i`=1:**
  - Latch `q_i` into Qr and `r_i` into Rr.
  - Clear the accumulator ACC (WIDTH+1 bits).
  - Load the counter with `WIDTH/2 - 1`.
- **RUN, one root bit per cycle, MSB first:**
  - `ACC <= (ACC << 1) + (Qr[cnt] ? Qr : 0)`.
  - Decrement the counter.
  - The counter is `$clog2(WIDTH/2)+1` bits wide.
- **DONE:**
  - `n_o <= (ACC + Rr)[WIDTH-1:0]`, using a WIDTH+1-bit sum.
  - `err_o <= (Rr > {Qr,1'b0})`.
  - `n_o` and `err_o` hold until the next DONE.
- **Width rule:** if `r ≤ 2q` then `q^2 + r ≤ 2^WIDTH - 1`, so a result with `err_o`=0 never overflows. When `err_o`=1 the result is wrapped modulo `2^WIDTH`.
- **`valid_o`:** a register loaded with `(state == DONE)`, so it is high for exactly one cycle.
- **Operand stability:** inputs and `start_i` are ignored outside IDLE. Operand changes after acceptance have no effect.
- **Reset:** `reset_i`=0 at any edge forces the following, with no `valid_o` for an aborted operation:
  - state to IDLE;
  - ACC, Qr, Rr and the counter to 0;
  - `n_o`, `err_o` and `valid_o` to 0.

## Timing
- Edge E0 samples `start_i` in IDLE.
- Edges E1…E(WIDTH/2) perform the RUN iterations; state is DONE after E(WIDTH/2).
- Edge E(WIDTH/2+1) loads `n_o`/`err_o`, sets `valid_o`, and returns the state to IDLE.
- `valid_o` is high during the cycle after E(WIDTH/2+1). Latency is WIDTH/2+1 edges after acceptance: 13 edges for WIDTH=24.
- `busy_o` is high from after E0 until after E(WIDTH/2+1). Throughput is one operation per WIDTH/2+2 cycles.
- **Back-to-back:** `start_i` held high during the `valid_o` cycle is accepted, because the state is IDLE then.
- **Held `start_i`:** a `start_i` held high continuously starts a new operation every WIDTH/2+2 cycles.
- **Start ignored while busy:** a `start_i` pulse while `busy_o`=1 is dropped, not queued.

## Test plan
- **Reset values:** reset, then idle 5 cycles → `n_o`=0, `err_o`=0, `valid_o`=0, `busy_o`=0.
- **Zero and typical operands:**
  - WIDTH=24, q=0, r=0 → `n_o`=0, `err_o`=0.
  - q=1234, r=100 → `n_o`=1522856, `err_o`=0; `valid_o` pulses exactly 13 edges after the start edge, for one cycle.
- **Boundary:**
  - q=4095, r=8190 → `n_o`=16777215, `err_o`=0.
  - q=4095, r=8191 → `n_o`=0 (wrapped), `err_o`=1.
  - q=5, r=11 → `n_o`=36, `err_o`=1.
- **Handshake:**
  - start q=3, r=2; pulse `start_i` with q=7 at busy cycle 4 → single result `n_o`=11; the second start is ignored.
  - Then assert `start_i` with q=7, r=0 during the `valid_o` cycle → accepted, `n_o`=49, 14 cycles later.
- **Reset mid-operation:** start q=100, r=0; drive `reset_i`=0 at RUN cycle 6 → next cycle state is IDLE, `busy_o`=0, `n_o`=0, and `valid_o` never pulses.
- **Round-trip:** 1000 random 24-bit n through the square-root unit into `int_square` → `n_o`==n and `err_o`=0 for every vector.
